issue_queue: RTL
================

Name: issue_queue

Overview:
- Parametrised successor to the single-slot issue stage: a DEPTH-entry in-order instruction queue between the instruction fetcher and the issue/dispatch logic.
- Buffers fetched instructions and classifies each by destination unit (ROB only, RS, or RS+LSB).
- Pops the head only when every unit it needs has room, then presents it on registered issue outputs.
- Supports a synchronous flush on branch misprediction.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 2.
- PTR_W, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction flush, synchronous
- if_valid  in  1  fetcher offers an instruction this cycle
- if_ins  in  32  instruction word
- if_pc  in  32  instruction pc
- if_pred_taken  in  1  predictor decision
- if_pred_pc  in  32  predicted next pc
- if_ready  out  1  queue can accept; equals (count != DEPTH)
- rob_full  in  1  ROB cannot take another entry
- rs_full  in  1  RS cannot take another entry
- lsb_full  in  1  LSB cannot take another entry
- iss_valid  out  1  one-cycle pulse: issue fields valid
- iss_class  out  2  0 = ROB only (LUI/AUIPC/JAL), 1 = RS (JALR/branch/I-type/R-type), 2 = RS+LSB (load/store)
- iss_ins  out  32  issued instruction word
- iss_pc  out  32  issued pc
- iss_pred_taken  out  1  issued prediction
- iss_pred_pc  out  32  issued predicted pc
- q_count  out  PTR_W+1  current occupancy

Behaviour:
- Storage: circular buffer with head and tail pointers (PTR_W bits, natural wrap) and a count register (PTR_W+1 bits).
- Each entry holds ins, pc, pred_taken, pred_pc and a 2-bit class.
- Class is computed from ins[6:0] at push time:
  - 0110111, 0010111, 1101111 -> class 0
  - 1100111, 1100011, 0010011, 0110011 -> class 1
  - 0000011, 0100011 -> class 2
  - any other opcode -> class 3
- Push: on the edge when if_valid && if_ready; writes the entry at tail; tail += 1.
- Pop-eligible when count != 0 and:
  - class 0: !rob_full
  - class 1: !rob_full && !rs_full
  - class 2: !rob_full && !rs_full && !lsb_full
  - class 3: always
- Pop: head += 1 on the edge.
  - For classes 0-2, the iss_* registers load the entry and iss_valid = 1 for exactly the next cycle.
  - Class 3 is discarded: no iss_valid pulse.
- If no pop occurs, iss_valid = 0 on the next cycle; the other iss_* fields hold their last values.
- Latency: an instruction pushed at edge k is issued at edge k+1 at the earliest, i.e. iss_valid is high in the cycle after edge k+1. There is no same-cycle bypass.
- Full flags are sampled in the pop cycle. The downstream units assert full with one entry of margin to cover the registered issue slot.
- Simultaneous push and pop: count is unchanged and both pointers advance. This applies at any occupancy where if_ready = 1.
- Full queue (count == DEPTH): if_ready = 0 and pushes are ignored, even if a pop happens in the same cycle.
- Empty queue: nothing is issued; if_ready = 1.
- flush (when rdy = 1): head = tail = count = 0 and iss_valid = 0 on the next cycle. Flush takes priority over a push and a pop in the same cycle.
- rdy = 0: all registers hold, including iss_valid; pushes and pops are ignored. flush is not honoured while rdy = 0; rst still is.
- rst: head = tail = count = 0; iss_valid = 0; iss_class = 0; iss_ins = iss_pc = iss_pred_pc = 0; iss_pred_taken = 0. rst overrides rdy and flush, including mid-stream.
- Entry storage is not reset.

Optional Feature:
- Macro ISSUE_QUEUE_PERF_EN.
- When defined, three 32-bit output counters are added, each saturating at 0xFFFFFFFF and cleared by rst (not by flush):
  - perf_issued: increments per iss_valid pulse.
  - perf_stall: increments for each rdy-high cycle in which count != 0 and the head is not pop-eligible.
  - perf_flushed: adds the count value at each honoured flush.
- When undefined, the ports and logic are absent.

Test Plan:
- Reset, then push ADDI 0x00100093 at pc 0x0 with rob/rs/lsb_full = 0 -> iss_valid pulses 2 cycles after the push edge; iss_class = 1, iss_ins = 0x00100093, q_count returns to 0.
- Push 8 LUIs with rob_full = 1 -> q_count = 8, if_ready = 0; a 9th push is ignored. Release rob_full -> 8 consecutive iss_valid pulses in pc order; no 9th.
- LW 0x0000A103 at the head with lsb_full = 1 and an ADD behind it -> no issue and the ADD does not bypass. Drop lsb_full -> LW issued with class 2, then the ADD with class 1.
- 4 entries queued, flush asserted together with if_valid -> next cycle q_count = 0, iss_valid = 0, and the pushed instruction is lost.
- Illegal opcode 0x0000007F queued between two LUIs -> exactly 2 iss_valid pulses. With ISSUE_QUEUE_PERF_EN, perf_issued = 2.
- rdy held low 3 cycles mid-stream with if_valid = 1 -> q_count, pointers and iss_valid are frozen. With ISSUE_QUEUE_PERF_EN and rs_full = 1 for 5 rdy-high cycles behind a class-1 head, perf_stall increments by 5.

Source files
------------

// File: rtl/issue_queue.sv
// In-order DEPTH-entry instruction queue between fetch and issue; head pops only when its target units have room.
// Optional ISSUE_QUEUE_PERF_EN adds saturating perf_issued / perf_stall / perf_flushed counters.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_ins,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_pc,
  output logic             if_ready,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             iss_valid,
  output logic [1:0]       iss_class,
  output logic [31:0]      iss_ins,
  output logic [31:0]      iss_pc,
  output logic             iss_pred_taken,
  output logic [31:0]      iss_pred_pc,
  output logic [PTR_W:0]   q_count
`ifdef ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flushed
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0] ins_mem [DEPTH];
  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] ppc_mem [DEPTH];
  logic        pt_mem  [DEPTH];
  logic [1:0]  cls_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             iss_valid_q, iss_valid_d;
  logic [1:0]       iss_class_q, iss_class_d;
  logic [31:0]      iss_ins_q, iss_ins_d, iss_pc_q, iss_pc_d, iss_ppc_q, iss_ppc_d;
  logic             iss_pt_q, iss_pt_d;

  logic       push, pop, head_ok;
  logic [1:0] hcls;

  function automatic logic [1:0] classify(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111:             classify = 2'd0;
      7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011: classify = 2'd1;
      7'b0000011, 7'b0100011:                         classify = 2'd2;
      default:                                        classify = 2'd3;
    endcase
  endfunction

  assign if_ready = (count_q != FULL_CNT);
  assign push     = if_valid && if_ready;

  always_comb begin
    hcls = cls_mem[head_q];
    case (hcls)
      2'd0:    head_ok = !rob_full;
      2'd1:    head_ok = !rob_full && !rs_full;
      2'd2:    head_ok = !rob_full && !rs_full && !lsb_full;
      default: head_ok = 1'b1;
    endcase
    pop = (count_q != '0) && head_ok;
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    iss_valid_d = iss_valid_q;
    iss_class_d = iss_class_q;
    iss_ins_d   = iss_ins_q;
    iss_pc_d    = iss_pc_q;
    iss_ppc_d   = iss_ppc_q;
    iss_pt_d    = iss_pt_q;
    if (rdy) begin
      iss_valid_d = 1'b0;
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop) begin
          head_d = head_q + PTR_W'(1);
          // Unknown opcodes leave the queue silently.
          if (hcls != 2'd3) begin
            iss_valid_d = 1'b1;
            iss_class_d = hcls;
            iss_ins_d   = ins_mem[head_q];
            iss_pc_d    = pc_mem[head_q];
            iss_ppc_d   = ppc_mem[head_q];
            iss_pt_d    = pt_mem[head_q];
          end
        end
        case ({push, pop})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_class_q <= '0;
      iss_ins_q   <= '0;
      iss_pc_q    <= '0;
      iss_ppc_q   <= '0;
      iss_pt_q    <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_class_q <= iss_class_d;
      iss_ins_q   <= iss_ins_d;
      iss_pc_q    <= iss_pc_d;
      iss_ppc_q   <= iss_ppc_d;
      iss_pt_q    <= iss_pt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && push) begin
      ins_mem[tail_q] <= if_ins;
      pc_mem[tail_q]  <= if_pc;
      ppc_mem[tail_q] <= if_pred_pc;
      pt_mem[tail_q]  <= if_pred_taken;
      cls_mem[tail_q] <= classify(if_ins[6:0]);
    end
  end

  assign iss_valid      = iss_valid_q;
  assign iss_class      = iss_class_q;
  assign iss_ins        = iss_ins_q;
  assign iss_pc         = iss_pc_q;
  assign iss_pred_taken = iss_pt_q;
  assign iss_pred_pc    = iss_ppc_q;
  assign q_count        = count_q;

`ifdef ISSUE_QUEUE_PERF_EN
  logic [31:0] perf_iss_q, perf_stall_q, perf_fl_q;
  logic [32:0] fl_sum;

  assign fl_sum = {1'b0, perf_fl_q} + 33'(count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_iss_q   <= '0;
      perf_stall_q <= '0;
      perf_fl_q    <= '0;
    end else if (rdy) begin
      if (!flush && pop && hcls != 2'd3 && perf_iss_q != '1)
        perf_iss_q <= perf_iss_q + 32'd1;
      if (count_q != '0 && !head_ok && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)
        perf_fl_q <= fl_sum[32] ? '1 : fl_sum[31:0];
    end
  end

  assign perf_issued  = perf_iss_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flushed = perf_fl_q;
`endif

endmodule
